// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyphs {g,f,e,d,c,b,a}
// and the digit-index type used to walk the four display positions.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Index order matches the anode numbering: an[0] is minute ones, an[3] is hour tens.
    typedef enum logic [1:0] {
        DIG_M0 = 2'd0,
        DIG_M1 = 2'd1,
        DIG_H0 = 2'd2,
        DIG_H1 = 2'd3
    } digit_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment glyph; non-decimal codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SEG_DASH;
        case (bcd)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 4-digit display driver with per-frame snapshot,
// anti-ghost guard and alarm blink. Optional macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 2500,
    parameter int GUARD       = 8,
    parameter int BLINK_DIV   = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       alarm_on,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int PW = $clog2(REFRESH_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [PW-1:0]   presc;
    digit_t          idx;
    logic [3:0][3:0] snap;
    logic            snap_pending;
    logic [BW-1:0]   blink_cnt;
    logic            blink_off;

    logic [3:0][3:0] live;
    logic [3:0][3:0] cur;
    logic [3:0]      digit;
    logic [6:0]      glyph;
    logic            presc_wrap;
    logic            frame_wrap;
    logic            blink_wrap;
    logic            blink_dark;
    logic            lead_dark;
    logic [3:0]      an_next;
    logic            dp_next;

    bcd_to_seg7 u_decode (
        .bcd   (digit),
        .glyph (glyph)
    );

    // Right after reset the snapshot register is still stale, so the live inputs are
    // shown directly for that one cycle while they are being captured.
    always_comb begin
        live       = {{2'b00, H_in1}, H_in0, M_in1, M_in0};
        cur        = snap_pending ? live : snap;
        digit      = cur[idx];
        presc_wrap = (presc == PW'(REFRESH_DIV - 1));
        frame_wrap = presc_wrap && (idx == DIG_H1);
        blink_wrap = alarm_on && (blink_cnt == BW'(BLINK_DIV - 1));
        blink_dark = alarm_on && blink_off;
`ifdef LEADING_ZERO_BLANK_EN
        lead_dark  = (idx == DIG_H1) && (cur[3] == 4'd0);
`else
        lead_dark  = 1'b0;
`endif
        an_next = (presc < PW'(GUARD)) ? 4'hF : ~(4'b0001 << idx);
        if (blank || blink_dark || lead_dark) begin
            an_next = 4'hF;
        end
        dp_next = ~((an_next != 4'hF) && (idx == DIG_H0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc        <= '0;
            idx          <= DIG_M0;
            snap         <= '0;
            snap_pending <= 1'b1;
            blink_cnt    <= '0;
            blink_off    <= 1'b0;
            seg          <= SEG_OFF;
            dp           <= 1'b1;
            an           <= 4'hF;
        end else begin
            snap_pending <= 1'b0;
            if (snap_pending || frame_wrap) begin
                snap <= live;
            end

            if (presc_wrap) begin
                presc <= '0;
                idx   <= digit_t'(idx + 2'd1);
            end else begin
                presc <= presc + PW'(1);
            end

            // Dropping the alarm parks the blink so the next alarm begins lit.
            if (!alarm_on) begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end else if (blink_wrap) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end

            seg <= glyph;
            dp  <= dp_next;
            an  <= an_next;
        end
    end

endmodule
